mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer that lets one single-port, fixed-latency unified memory serve both the pipeline's instruction-fetch stage and its memory-access stage. It accepts held requests from both stages and grants one transaction at a time, round-robin on conflicts. It drives the memory port, counts the memory latency, and returns registered read data with a one-cycle ready pulse. It also produces the stall signals that freeze the IF and MEM stages while their access is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 2, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held until if_ready
- if_addr  input  ADDR_W  fetch address; stable while if_req is high
- if_rdata  output  DATA_W  fetched instruction; valid in the if_ready cycle
- if_ready  output  1  one-cycle completion pulse for fetch
- dm_req  input  1  data request; held until dm_ready
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_wmask  input  DATA_W/8  byte-lane write enables
- dm_rdata  output  DATA_W  load data; valid in the dm_ready cycle
- dm_ready  output  1  one-cycle completion pulse for data
- mem_en  output  1  memory access strobe, one cycle per transaction
- mem_we  output  1  memory write enable; qualified by mem_en
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_wmask  output  DATA_W/8  memory byte mask; 0 for reads
- mem_rdata  input  DATA_W  memory read data
- stallF  output  1  if_req & ~if_ready (combinational)
- stallM  output  1  dm_req & ~dm_ready (combinational)

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - ISSUE: mem_en is driven.
  - WAIT: latency counter running.
  - DONE: ready pulse.
- IDLE: eligible requesters are if_req and dm_req, excluding any requester whose ready is high this cycle.
  - With no eligible request, the FSM stays in IDLE.
  - Otherwise it grants one requester, latches owner, address, we, wdata and wmask, and goes to ISSUE.
- Arbitration: a single request is granted directly. When both request, the grant goes to the requester not served last (last_grant flag). last_grant resets to IF, so the first tie goes to DM.
- ISSUE: mem_en=1, and mem_we, mem_addr, mem_wdata, mem_wmask come from the latched values. The 4-bit counter loads LATENCY-1. Next state is WAIT.
- WAIT: the counter decrements each cycle. When the counter reaches 0, mem_rdata is sampled:
  - Owner DM with dm_we=0: sampled into dm_rdata.
  - Owner IF: sampled into if_rdata.
  - The FSM then goes to DONE.
- DONE: the owner's ready is 1 for exactly one cycle, last_grant is updated to the owner, and the FSM returns to IDLE.
- DONE and IDLE are distinct states. A requester whose ready is high is ineligible in that cycle, so the same request is never issued twice.
- Stores: the address, data and mask reach memory in ISSUE. dm_ready pulses after the same latency as a load, and dm_rdata is not updated.
- if_rdata and dm_rdata hold their last loaded value until the next read completes for that requester.
- Outside ISSUE, mem_en, mem_we and mem_wmask are 0, and mem_addr and mem_wdata hold their last values.
- Requests that drop before ready are a protocol violation. The transaction still completes and the ready pulse is still produced.

## Timing
- Reset, synchronous, takes effect at the next edge. Reset values:
  - state = IDLE
  - last_grant = IF
  - counter = 0
  - mem_en, mem_we, mem_wmask = 0
  - mem_addr, mem_wdata = 0
  - if_ready, dm_ready = 0
  - if_rdata, dm_rdata = 0
- Reset mid-transaction abandons the access: no ready pulse is produced and there is no further mem_en.
- The request is sampled in IDLE at cycle t. The sequence is then:
  - mem_en at t+1
  - mem_rdata sampled at t+1+LATENCY
  - ready and rdata at t+2+LATENCY
- The next grant decision is made at t+3+LATENCY, so the per-transaction occupancy is LATENCY+3 cycles.
- stallF and stallM are combinational from the requests and the registered ready signals. They are low in the ready cycle.

## Test plan
- Reset with if_req=1 asserted → all outputs 0 while reset is high. After release (LATENCY=2): mem_en at cycle 1 with mem_addr=if_addr; if_ready and if_rdata = mem_rdata at cycle 4.
- Lone load, dm_addr=0x100, memory returns 0xDEADBEEF → dm_ready pulses once with dm_rdata=0xDEADBEEF; mem_we=0 and mem_wmask=0 during the access; if_rdata unchanged.
- Store, dm_addr=0x104, wdata=0x12345678, wmask=4'b0011 → one mem_en cycle with mem_we=1 and those exact values; dm_ready pulses after LATENCY+2 cycles; dm_rdata unchanged.
- if_req and dm_req both high from reset and held → DM is served first, then IF, then DM again. Exactly one mem_en per transaction, and no ready pulse without a matching mem_en.
- Requester keeps its request high in its ready cycle and then drops it → no second issue. A continuously held request from the other requester is granted in the next IDLE.
- Reset asserted during WAIT → no ready pulse. After release a fresh grant follows the normal timing, and last_grant is IF.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the unified memory
// port and the mem_arbiter that sequences accesses between them.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W/8-1:0]   dm_wmask;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_ready;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  stallF;
    logic                  stallM;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
        output dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata,
        output stallF, stallM
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wmask,
        input  dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata,
        input  stallF, stallM
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency memory port
// between instruction fetch and data access, with stage stall outputs.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    mem_arbiter_if.slave bus
);
    localparam int MW = DATA_W / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic              last_dm_q, last_dm_d;
    logic              own_dm_q, own_dm_d;
    logic              op_we_q, op_we_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [MW-1:0]     mem_wmask_q, mem_wmask_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic              elig_if;
    logic              elig_dm;
    logic              pick_dm;

    // A requester in its ready cycle is still holding the finished
    // request, so it must not be seen as a new one.
    assign elig_if = bus.if_req & ~if_ready_q;
    assign elig_dm = bus.dm_req & ~dm_ready_q;
    assign pick_dm = elig_dm & (~elig_if | ~last_dm_q);

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        own_dm_d    = own_dm_q;
        op_we_d     = op_we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wmask_d = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (elig_if | elig_dm) begin
                    state_d  = ISSUE;
                    own_dm_d = pick_dm;
                    mem_en_d = 1'b1;
                    if (pick_dm) begin
                        op_we_d     = bus.dm_we;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        mem_wmask_d = bus.dm_we ? bus.dm_wmask : '0;
                    end else begin
                        op_we_d    = 1'b0;
                        mem_addr_d = bus.if_addr;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (own_dm_q) begin
                        dm_ready_d = 1'b1;
                        if (!op_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                last_dm_d = own_dm_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_dm_q   <= 1'b0;
            own_dm_q    <= 1'b0;
            op_we_q     <= 1'b0;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            own_dm_q    <= own_dm_d;
            op_we_q     <= op_we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_wmask_q <= mem_wmask_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stallF    = bus.if_req & ~if_ready_q;
    assign bus.stallM    = bus.dm_req & ~dm_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked
// against a transaction-timing reference model and a memory shadow.
module tb_mem_arbiter;
    localparam int LAT = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dreq_t;

    logic clk;
    logic reset;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [31:0] dev [logic [31:0]];
    logic [31:0] shd [logic [31:0]];

    // stimulus state
    bit          if_hold, dm_hold;
    bit          if_on, dm_on;
    int          p_if, p_dm;
    logic [31:0] iq [$];
    dreq_t       dq [$];

    // reference model state
    int          cyc = 0;
    int          s_cyc = -1000;
    bit          own_dm, last_dm;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_val;
    logic [3:0]  m_mask;
    logic [31:0] exp_addr, exp_if_rd, exp_dm_rd;

    // memory device state
    bit          pend;
    int          pend_cyc;
    logic [31:0] pend_addr;

    // statistics since last clear
    int          mark, n_en, n_rdy, first_en, first_rdy;
    bit          done_q [$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev.exists(a) ? dev[a] : init_val(a);
    endfunction

    function automatic logic [31:0] shd_rd(input logic [31:0] a);
        return shd.exists(a) ? shd[a] : init_val(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] mk);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (mk[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s obs=%b exp=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        mark = cyc;
        n_en = 0;
        n_rdy = 0;
        first_en = -1;
        first_rdy = -1;
        done_q.delete();
    endtask

    task automatic cycle(input bit rst);
        bit rdy_if, rdy_dm, en, el_if, el_dm, gdm;
        dreq_t d;
        @(negedge clk);
        reset = rst;
        rdy_if = (cyc == s_cyc + 2 + LAT) && !own_dm;
        rdy_dm = (cyc == s_cyc + 2 + LAT) && own_dm;

        if (rdy_if) begin
            bus.if_req = 1'($urandom_range(0, 1));
            if_hold = 1'b0;
        end else begin
            if (!if_hold) begin
                if (iq.size() != 0) begin
                    if_hold = 1'b1;
                    bus.if_addr = iq.pop_front();
                end else if (if_on && $urandom_range(0, 99) < p_if) begin
                    if_hold = 1'b1;
                    bus.if_addr = rnd_addr();
                end
            end
            bus.if_req = if_hold;
        end

        if (rdy_dm) begin
            bus.dm_req = 1'($urandom_range(0, 1));
            dm_hold = 1'b0;
        end else begin
            if (!dm_hold) begin
                if (dq.size() != 0) begin
                    d = dq.pop_front();
                    dm_hold = 1'b1;
                    bus.dm_we = d.we;
                    bus.dm_addr = d.addr;
                    bus.dm_wdata = d.wdata;
                    bus.dm_wmask = d.mask;
                end else if (dm_on && $urandom_range(0, 99) < p_dm) begin
                    dm_hold = 1'b1;
                    bus.dm_we = 1'($urandom_range(0, 1));
                    bus.dm_addr = rnd_addr();
                    bus.dm_wdata = $urandom;
                    bus.dm_wmask = 4'($urandom);
                end
            end
            bus.dm_req = dm_hold;
        end

        bus.mem_rdata = (pend && cyc == pend_cyc + LAT) ?
                        dev_rd(pend_addr) : $urandom;

        en = (cyc == s_cyc + 1);
        if (en) begin
            exp_addr = m_addr;
            if (m_we) shd[m_addr] = merge(shd_rd(m_addr), m_wdata, m_mask);
        end
        if (cyc == s_cyc + 2 + LAT) begin
            if (!own_dm) exp_if_rd = m_val;
            else if (!m_we) exp_dm_rd = m_val;
            last_dm = own_dm;
        end

        #1;
        chk1("mem_en", bus.mem_en, en);
        chk1("mem_we", bus.mem_we, en && m_we);
        chk32("mem_wmask", 32'(bus.mem_wmask), (en && m_we) ? 32'(m_mask) : 32'd0);
        chk32("mem_addr", bus.mem_addr, exp_addr);
        if (en && m_we) chk32("mem_wdata", bus.mem_wdata, m_wdata);
        chk1("if_ready", bus.if_ready, rdy_if);
        chk1("dm_ready", bus.dm_ready, rdy_dm);
        chk32("if_rdata", bus.if_rdata, exp_if_rd);
        chk32("dm_rdata", bus.dm_rdata, exp_dm_rd);
        chk1("stallF", bus.stallF, bus.if_req && !rdy_if);
        chk1("stallM", bus.stallM, bus.dm_req && !rdy_dm);

        if (!rst && cyc >= s_cyc + 3 + LAT) begin
            el_if = bus.if_req && !rdy_if;
            el_dm = bus.dm_req && !rdy_dm;
            if (el_if || el_dm) begin
                gdm = el_dm && (!el_if || !last_dm);
                own_dm = gdm;
                s_cyc = cyc;
                if (gdm) begin
                    m_we = bus.dm_we;
                    m_addr = bus.dm_addr;
                    m_wdata = bus.dm_wdata;
                    m_mask = bus.dm_wmask;
                end else begin
                    m_we = 1'b0;
                    m_addr = bus.if_addr;
                end
                m_val = shd_rd(m_addr);
            end
        end

        if (bus.mem_en) begin
            pend = 1'b1;
            pend_cyc = cyc;
            pend_addr = bus.mem_addr;
            if (bus.mem_we)
                dev[bus.mem_addr] = merge(dev_rd(bus.mem_addr),
                                          bus.mem_wdata, bus.mem_wmask);
            n_en++;
            if (first_en < 0) first_en = cyc - mark;
        end
        if (bus.if_ready || bus.dm_ready) begin
            n_rdy++;
            if (first_rdy < 0) first_rdy = cyc - mark;
            done_q.push_back(bus.dm_ready);
        end

        if (rst) begin
            s_cyc = -1000;
            own_dm = 1'b0;
            last_dm = 1'b0;
            exp_addr = '0;
            exp_if_rd = '0;
            exp_dm_rd = '0;
            pend = 1'b0;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wdata = '0;
        bus.dm_wmask = '0;
        bus.mem_rdata = '0;
        if_on = 1'b0;
        dm_on = 1'b0;
        p_if = 0;
        p_dm = 0;
        clear_stats();

        // reset with a fetch pending, then first fetch timing
        iq.push_back(32'h40);
        repeat (3) cycle(1'b1);
        chk1("a_no_en_in_reset", n_en == 0, 1'b1);
        clear_stats();
        run(8);
        chk32("a_first_en", 32'(first_en), 32'd1);
        chk32("a_first_rdy", 32'(first_rdy), 32'(LAT + 2));
        chk32("a_if_rdata", bus.if_rdata, init_val(32'h40));

        // lone load
        dev[32'h100] = 32'hDEADBEEF;
        shd[32'h100] = 32'hDEADBEEF;
        dq.push_back('{1'b0, 32'h100, 32'hFFFF_FFFF, 4'hF});
        clear_stats();
        run(8);
        chk32("b_dm_rdata", bus.dm_rdata, 32'hDEADBEEF);
        chk32("b_if_rdata", bus.if_rdata, init_val(32'h40));
        chk32("b_n_en", 32'(n_en), 32'd1);
        chk32("b_n_rdy", 32'(n_rdy), 32'd1);

        // store
        dq.push_back('{1'b1, 32'h104, 32'h12345678, 4'b0011});
        clear_stats();
        run(8);
        v = init_val(32'h104);
        v[15:0] = 16'h5678;
        chk32("c_mem_word", dev_rd(32'h104), v);
        chk32("c_first_en", 32'(first_en), 32'd1);
        chk32("c_first_rdy", 32'(first_rdy), 32'(LAT + 2));
        chk32("c_n_en", 32'(n_en), 32'd1);
        chk32("c_dm_rdata", bus.dm_rdata, 32'hDEADBEEF);

        // both held from reset: DM, IF, DM
        if_on = 1'b1;
        dm_on = 1'b1;
        p_if = 100;
        p_dm = 100;
        repeat (2) cycle(1'b1);
        clear_stats();
        run(3 * (LAT + 3) + 2);
        chk1("d_three_done", done_q.size() >= 3, 1'b1);
        if (done_q.size() >= 3) begin
            chk1("d_order0", done_q[0], 1'b1);
            chk1("d_order1", done_q[1], 1'b0);
            chk1("d_order2", done_q[2], 1'b1);
        end
        chk1("d_rdy_le_en", n_rdy <= n_en, 1'b1);

        // reset during WAIT abandons the fetch; last_grant back to IF
        if_on = 1'b0;
        dm_on = 1'b0;
        if_hold = 1'b0;
        dm_hold = 1'b0;
        cycle(1'b1);
        iq.push_back(32'h3C);
        clear_stats();
        run(3);
        repeat (2) cycle(1'b1);
        chk32("e_n_en", 32'(n_en), 32'd1);
        chk32("e_no_rdy", 32'(n_rdy), 32'd0);
        dq.push_back('{1'b0, 32'h08, 32'h0, 4'h0});
        clear_stats();
        run(2 * (LAT + 3) + 2);
        chk32("e_first_en", 32'(first_en), 32'd1);
        chk32("e_first_rdy", 32'(first_rdy), 32'(LAT + 2));
        chk1("e_two_done", done_q.size() >= 2, 1'b1);
        if (done_q.size() >= 2) begin
            chk1("e_order0", done_q[0], 1'b1);
            chk1("e_order1", done_q[1], 1'b0);
        end

        // random traffic
        if_on = 1'b1;
        dm_on = 1'b1;
        p_if = 35;
        p_dm = 35;
        clear_stats();
        run(3000);
        chk1("f_activity", n_rdy > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
